// File: rtl/apb_requester.sv
// APB4 requester: turns valid/ready commands into SETUP/ACCESS bus transfers,
// decodes the upper address bits into a one-hot PSEL, rejects misaligned
// addresses locally and aborts transfers whose PREADY never arrives.
module apb_requester #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned NUM_SEL        = 4,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                    pclk,
  input  logic                    reset,
  // Command port
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_strb,
  input  logic [2:0]              cmd_prot,
  // Response port
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_slverr,
  output logic                    rsp_timeout,
  // APB bus
  output logic [NUM_SEL-1:0]      psel,
  output logic                    penable,
  output logic                    pwrite,
  output logic [ADDR_WIDTH-1:0]   paddr,
  output logic [DATA_WIDTH-1:0]   pwdata,
  output logic [DATA_WIDTH/8-1:0] pstrb,
  output logic [2:0]              pprot,
  input  logic [DATA_WIDTH-1:0]   prdata,
  input  logic                    pready,
  input  logic                    pslverr
);

  localparam int unsigned SelW = (NUM_SEL > 1) ? $clog2(NUM_SEL) : 1;
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

  state_e                  state_q;
  logic [NUM_SEL-1:0]      psel_q;
  logic                    penable_q;
  logic                    pwrite_q;
  logic [ADDR_WIDTH-1:0]   paddr_q;
  logic [DATA_WIDTH-1:0]   pwdata_q;
  logic [DATA_WIDTH/8-1:0] pstrb_q;
  logic [2:0]              pprot_q;
  logic                    rsp_valid_q;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q;
  logic                    rsp_slverr_q;
  logic                    rsp_timeout_q;
  logic [CntW-1:0]         tmo_cnt_q;

  logic [SelW-1:0]         sel_idx;
  logic [NUM_SEL-1:0]      sel_onehot;
  logic                    misaligned;
  logic                    tmo_hit;

  // Peripheral index comes from the top address bits; a single peripheral is always selected.
  assign sel_idx    = (NUM_SEL == 1) ? '0 : cmd_addr[ADDR_WIDTH-1 -: SelW];
  assign sel_onehot = NUM_SEL'(1) << sel_idx;
  assign misaligned = (cmd_addr[1:0] != 2'b00);

  // This wait cycle would be the TIMEOUT_CYCLES-th with PREADY low.
  assign tmo_hit = (TIMEOUT_CYCLES != 0) &&
                   ((32'(tmo_cnt_q) + 32'd1) == TIMEOUT_CYCLES);

  // Transfer sequencing with all bus and response outputs registered.
  always_ff @(posedge pclk) begin
    if (reset) begin
      state_q       <= StIdle;
      psel_q        <= '0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      pstrb_q       <= '0;
      pprot_q       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_slverr_q  <= 1'b0;
      rsp_timeout_q <= 1'b0;
      tmo_cnt_q     <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cmd_valid) begin
            if (misaligned) begin
              // Rejected locally: the bus is never touched.
              state_q       <= StResp;
              rsp_valid_q   <= 1'b1;
              rsp_rdata_q   <= '0;
              rsp_slverr_q  <= 1'b1;
              rsp_timeout_q <= 1'b0;
            end else begin
              state_q   <= StSetup;
              psel_q    <= sel_onehot;
              penable_q <= 1'b0;
              pwrite_q  <= cmd_write;
              paddr_q   <= cmd_addr;
              pwdata_q  <= cmd_wdata;
              pstrb_q   <= cmd_write ? cmd_strb : '0;
              pprot_q   <= cmd_prot;
              tmo_cnt_q <= '0;
            end
          end
        end
        StSetup: begin
          state_q   <= StAccess;
          penable_q <= 1'b1;
        end
        StAccess: begin
          if (pready) begin
            state_q       <= StResp;
            psel_q        <= '0;
            penable_q     <= 1'b0;
            rsp_valid_q   <= 1'b1;
            rsp_rdata_q   <= (pwrite_q || pslverr) ? '0 : prdata;
            rsp_slverr_q  <= pslverr;
            rsp_timeout_q <= 1'b0;
          end else if (tmo_hit) begin
            state_q       <= StResp;
            psel_q        <= '0;
            penable_q     <= 1'b0;
            rsp_valid_q   <= 1'b1;
            rsp_rdata_q   <= '0;
            rsp_slverr_q  <= 1'b1;
            rsp_timeout_q <= 1'b1;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + CntW'(1);
          end
        end
        StResp: begin
          if (rsp_ready) begin
            state_q     <= StIdle;
            rsp_valid_q <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign cmd_ready   = (state_q == StIdle) && !reset;
  assign psel        = psel_q;
  assign penable     = penable_q;
  assign pwrite      = pwrite_q;
  assign paddr       = paddr_q;
  assign pwdata      = pwdata_q;
  assign pstrb       = pstrb_q;
  assign pprot       = pprot_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_slverr  = rsp_slverr_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_requester.sv
// Directed bench for apb_requester: the stimulus process drives commands and a
// peripheral model, pushing expected responses; a monitor pops them on handshake.
module tb_apb_requester;

  logic        pclk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_strb;
  logic [2:0]  cmd_prot;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_slverr;
  logic        rsp_timeout;
  logic [3:0]  psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [2:0]  pprot;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  typedef struct packed {
    logic [31:0] rdata;
    logic        slverr;
    logic        timeout;
  } rsp_t;

  rsp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  apb_requester #(
    .ADDR_WIDTH    (32),
    .DATA_WIDTH    (32),
    .NUM_SEL       (4),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .pclk       (pclk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_write  (cmd_write),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .cmd_strb   (cmd_strb),
    .cmd_prot   (cmd_prot),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_slverr (rsp_slverr),
    .rsp_timeout(rsp_timeout),
    .psel       (psel),
    .penable    (penable),
    .pwrite     (pwrite),
    .paddr      (paddr),
    .pwdata     (pwdata),
    .pstrb      (pstrb),
    .pprot      (pprot),
    .prdata     (prdata),
    .pready     (pready),
    .pslverr    (pslverr)
  );

  always #5 pclk = ~pclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: settles after the negedge drive, then checks any handshake due at the next posedge.
  always @(negedge pclk) begin
    #1;
    if (!reset && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL rsp_unexpected: got rdata %h slverr %b timeout %b, expected none",
                 rsp_rdata, rsp_slverr, rsp_timeout);
      end else begin
        rsp_t e;
        e = exp_q.pop_front();
        check("rsp_rdata", rsp_rdata, e.rdata);
        check("rsp_slverr", {31'd0, rsp_slverr}, {31'd0, e.slverr});
        check("rsp_timeout", {31'd0, rsp_timeout}, {31'd0, e.timeout});
      end
    end
  end

  // waits < 0 means the peripheral never raises PREADY. Entered and left at a negedge in IDLE.
  task automatic run_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] strb, input logic [2:0] prot, input int waits,
                         input logic [31:0] rd, input logic err, input logic [3:0] exp_sel,
                         input int hold);
    rsp_t e;
    logic mis;
    int   n_acc;
    mis = (addr[1:0] != 2'b00);
    if (mis)            e = '{rdata: 32'd0, slverr: 1'b1, timeout: 1'b0};
    else if (waits < 0) e = '{rdata: 32'd0, slverr: 1'b1, timeout: 1'b1};
    else                e = '{rdata: (wr || err) ? 32'd0 : rd, slverr: err, timeout: 1'b0};
    exp_q.push_back(e);
    rsp_ready = (hold == 0);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    cmd_strb  = strb;
    cmd_prot  = prot;
    check("cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
    @(negedge pclk);
    cmd_valid = 1'b0;
    if (mis) begin
      check("mis_psel", {28'd0, psel}, 32'd0);
      check("mis_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    end else begin
      check("setup_psel", {28'd0, psel}, {28'd0, exp_sel});
      check("setup_penable", {31'd0, penable}, 32'd0);
      check("setup_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      n_acc = (waits < 0) ? 16 : waits + 1;
      for (int i = 0; i < n_acc; i++) begin
        @(negedge pclk);
        check("acc_penable", {31'd0, penable}, 32'd1);
        check("acc_psel", {28'd0, psel}, {28'd0, exp_sel});
        check("acc_paddr", paddr, addr);
        check("acc_pwdata", pwdata, wdata);
        check("acc_pstrb", {28'd0, pstrb}, wr ? {28'd0, strb} : 32'd0);
        check("acc_pprot", {29'd0, pprot}, {29'd0, prot});
        check("acc_pwrite", {31'd0, pwrite}, {31'd0, wr});
        check("acc_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        pready  = (i == waits);
        pslverr = err;
        prdata  = rd;
      end
      @(negedge pclk);
      pready  = 1'b0;
      pslverr = 1'b0;
      check("end_psel", {28'd0, psel}, 32'd0);
      check("end_penable", {31'd0, penable}, 32'd0);
      check("end_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    end
    for (int h = 0; h < hold; h++) begin
      check("hold_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check("hold_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      check("hold_rdata", rsp_rdata, e.rdata);
      check("hold_slverr", {31'd0, rsp_slverr}, {31'd0, e.slverr});
      @(negedge pclk);
    end
    rsp_ready = 1'b1;
    if (waits < 0 && !mis) pready = 1'b1;  // late PREADY after abort
    @(negedge pclk);
    pready = 1'b0;
    check("after_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("after_psel", {28'd0, psel}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1);
  end

  initial begin
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    cmd_strb  = '0;
    cmd_prot  = '0;
    rsp_ready = 1'b1;
    prdata    = '0;
    pready    = 1'b0;
    pslverr   = 1'b0;
    repeat (2) @(negedge pclk);
    check("rst_psel", {28'd0, psel}, 32'd0);
    check("rst_penable", {31'd0, penable}, 32'd0);
    check("rst_paddr", paddr, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    reset = 1'b0;
    @(negedge pclk);

    // Zero-wait read; strobes must be dropped on reads.
    run_cmd(1'b0, 32'h0000_0004, 32'h0, 4'hF, 3'b000, 0, 32'hDEAD_BEEF, 1'b0, 4'b0001, 0);
    // Write with 3 wait states and a response held for 5 cycles.
    run_cmd(1'b1, 32'h4000_0010, 32'h1234_5678, 4'b0011, 3'b010, 3, 32'hFFFF_FFFF, 1'b0,
            4'b0010, 5);
    // Misaligned read rejected locally.
    run_cmd(1'b0, 32'h0000_0003, 32'h0, 4'h0, 3'b000, 0, 32'h0, 1'b0, 4'b0000, 0);
    // Peripheral error on read.
    run_cmd(1'b0, 32'hC000_0008, 32'h0, 4'h0, 3'b101, 1, 32'hA5A5_A5A5, 1'b1, 4'b1000, 0);
    // Timeout after 16 ACCESS cycles, then a late PREADY.
    run_cmd(1'b0, 32'h8000_0000, 32'h0, 4'h0, 3'b001, -1, 32'h1111_1111, 1'b0, 4'b0100, 0);

    // Reset during ACCESS.
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 32'h4000_0020;
    cmd_wdata = 32'hCAFE_F00D;
    cmd_strb  = 4'hF;
    cmd_prot  = 3'b111;
    @(negedge pclk);
    cmd_valid = 1'b0;
    repeat (2) @(negedge pclk);
    check("pre_rst_penable", {31'd0, penable}, 32'd1);
    reset = 1'b1;
    @(negedge pclk);
    check("midrst_psel", {28'd0, psel}, 32'd0);
    check("midrst_penable", {31'd0, penable}, 32'd0);
    check("midrst_pwrite", {31'd0, pwrite}, 32'd0);
    check("midrst_paddr", paddr, 32'd0);
    check("midrst_pwdata", pwdata, 32'd0);
    check("midrst_pstrb", {28'd0, pstrb}, 32'd0);
    check("midrst_pprot", {29'd0, pprot}, 32'd0);
    check("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("midrst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    reset = 1'b0;
    @(negedge pclk);
    check("postrst_cmd_ready", {31'd0, cmd_ready}, 32'd1);

    // Recovery: write with one wait state to peripheral 1.
    run_cmd(1'b1, 32'h7FFF_FFFC, 32'h0BAD_F00D, 4'b1100, 3'b100, 1, 32'h0, 1'b0, 4'b0010, 0);

    repeat (2) @(negedge pclk);
    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/apb_requester.md
Name: apb_requester

Overview:
Synthesizable, parametrised APB4 requester that replaces the behavioural bridge sequencing. It accepts read/write commands on a valid/ready command port and drives the APB bus through SETUP and ACCESS phases. It decodes the address to one of NUM_SEL peripheral selects and returns read data plus error status on a valid/ready response port. Behaviour the behavioural bridge lacks: local rejection of misaligned addresses, a PREADY timeout, and multi-peripheral PSEL decode.

Parameters:
ADDR_WIDTH, 32, APB address width
DATA_WIDTH, 32, APB data width (32 only; PSTRB width = DATA_WIDTH/8)
NUM_SEL, 4, number of peripheral selects (power of two, >=1)
TIMEOUT_CYCLES, 16, max ACCESS cycles with PREADY low before abort; 0 disables timeout

Ports:
pclk  in  1  APB clock
reset  in  1  reset, synchronous, active-high
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when valid&ready
cmd_write  in  1  1=write, 0=read
cmd_addr  in  ADDR_WIDTH  byte address
cmd_wdata  in  DATA_WIDTH  write data
cmd_strb  in  DATA_WIDTH/8  write strobes (forced 0 on reads)
cmd_prot  in  3  PPROT value
rsp_valid  out  1  response present
rsp_ready  in  1  response consumed when valid&ready
rsp_rdata  out  DATA_WIDTH  read data (0 for writes or errors)
rsp_slverr  out  1  PSLVERR seen, misalignment, or timeout
rsp_timeout  out  1  transfer aborted by timeout
psel  out  NUM_SEL  one-hot peripheral select
penable, pwrite  out  1  APB control
paddr  out  ADDR_WIDTH  APB address
pwdata  out  DATA_WIDTH  APB write data
pstrb  out  DATA_WIDTH/8  APB strobes
pprot  out  3  APB protection
prdata  in  DATA_WIDTH  read data from selected peripheral (muxed externally)
pready, pslverr  in  1  from selected peripheral

Behaviour:
- Reset (sampled on pclk rising edge while reset=1): state IDLE; psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, pstrb=0, pprot=0, rsp_valid=0, rsp_rdata=0, rsp_slverr=0, rsp_timeout=0, timeout counter=0. An in-flight transfer or held response is discarded. cmd_ready=0 while reset=1.
- States: IDLE, SETUP, ACCESS, RESP.
- IDLE: cmd_ready=1. On cmd_valid, capture the command.
  - If cmd_addr[1:0]!=0: go to RESP with rsp_slverr=1, rsp_timeout=0, rsp_rdata=0. No bus activity.
  - Otherwise: go to SETUP.
- SETUP (exactly 1 cycle): psel[idx]=1, where idx=paddr[ADDR_WIDTH-1 -: log2(NUM_SEL)] (idx=0 when NUM_SEL=1). penable=0. paddr, pwrite, pwdata, pstrb and pprot are driven from the captured command. Next state ACCESS.
- ACCESS: penable=1 with psel held. All address, control and data outputs stay stable until exit.
  - On pready=1: capture prdata (reads only; writes return 0) and pslverr. Deassert psel and penable on the next edge. Go to RESP.
  - Each cycle with pready=0 increments the timeout counter. When the counter reaches TIMEOUT_CYCLES (if nonzero): deassert psel and penable, go to RESP with rsp_slverr=1, rsp_timeout=1, rsp_rdata=0.
  - A late pready after abort is ignored.
- RESP: rsp_valid=1 with fields held stable. On rsp_ready, clear rsp_valid and go to IDLE. cmd_ready=0 in RESP. Minimum command-to-command spacing is therefore 4 cycles.
- Latency: a read with a zero-wait peripheral accepted at edge N has psel at N+1, penable at N+2, and rsp_valid at N+3.
- Timeout counter clears on entry to SETUP. Minimum ACCESS length is 1 cycle.
- pstrb is 0 for reads regardless of cmd_strb.

Test Plan:
- Read, addr 0x0000_0004, prot 3'b000, pready=1 immediately, prdata=0xDEADBEEF -> psel=4'b0001, SETUP then one ACCESS cycle; rsp_rdata=0xDEADBEEF, slverr=0, rsp_valid 3 cycles after accept.
- Write, addr 0x4000_0010, wdata 0x1234_5678, strb 4'b0011, pready low for 3 cycles -> psel=4'b0010; paddr, pwdata and pstrb stable across 4 ACCESS cycles; rsp_rdata=0, slverr=0.
- Misaligned read, addr 0x0000_0003 -> no psel pulse; rsp_slverr=1, rsp_timeout=0 one cycle after accept.
- Peripheral error, read addr 0xC000_0008 with pslverr=1 on the pready cycle -> psel=4'b1000; rsp_slverr=1, rsp_timeout=0.
- Timeout, TIMEOUT_CYCLES=16, pready held low -> psel and penable drop after 16 ACCESS cycles; rsp_slverr=1, rsp_timeout=1; a later pready pulse is ignored.
- Reset mid-ACCESS, plus rsp_ready held low for 5 cycles -> reset clears all outputs on the next edge. In the held case, rsp fields stay stable and cmd_ready stays 0 until the handshake completes.
